alu_exec_stage: RTL and testbench
=================================

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 Parameter L, default 16: data width of operands, result and flags.
REQ-002 Parameter P, default 0: MSB index of the op-select field (op width P+1).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  upstream offers an operation.
REQ-006 in_ready  output  1  stage accepts the offer this cycle.
REQ-007 in_op  input  P+1  ALU operation select (0 = divide, 1 = multiply).
REQ-008 in_a  input  L  signed operand A.
REQ-009 in_b  input  L  signed operand B.
REQ-010 out_valid  output  1  registered result available.
REQ-011 out_ready  input  1  downstream consumes the result this cycle.
REQ-012 out_r  output  L  signed registered ALU result.
REQ-013 out_flags  output  L  registered ALU FlagsOut captured with out_r.
REQ-014 flags  output  L  architectural flag register, fed back as ALU FlagsIn.
REQ-015 flags_clr  input  1  synchronous clear of the flag register.

Function
REQ-016 The block SHALL be two register stages: S1 (op, A, B, s1_valid) -> combinational ALU -> S2 (r, flags, s2_valid).
REQ-017 Transfer in: in_valid && in_ready at a rising edge loads S1 and sets s1_valid.
REQ-018 Transfer out: out_valid && out_ready at a rising edge retires S2.
REQ-019 s2_load = s1_valid && (!s2_valid || out_ready); on s2_load S2 captures ALU R and FlagsOut, s2_valid set.
REQ-020 s1_valid SHALL clear on s2_load with no simultaneous input transfer; s2_valid SHALL clear on retire with no simultaneous s2_load.
REQ-021 in_ready = !s1_valid || s2_load (combinational; full throughput, one op per cycle sustained).
REQ-022 Latency: op accepted at edge N SHALL present out_valid in the cycle after edge N+1 when out_ready held high.
REQ-023 While out_valid && !out_ready, out_r, out_flags, out_valid SHALL hold stable; S1 holds; in_ready low once S1 full.
REQ-024 ALU FlagsIn SHALL be the flags register; flags register loads ALU FlagsOut on every s2_load.
REQ-025 flags_clr SHALL zero the flags register at the edge; if coincident with s2_load, clear wins for the flags register (out_flags still captures FlagsOut).
REQ-026 Back-to-back ops: the second op SHALL see the flags produced by the first (flags update same edge first op enters S2).
REQ-027 Arithmetic, overflow, divide-by-zero result values SHALL be exactly the ALU's; this block adds no width conversion.
REQ-028 Upstream SHALL hold in_op/in_a/in_b stable while in_valid && !in_ready; block samples only on transfer.

Reset
REQ-029 On rst high, immediately: s1_valid=0, s2_valid=0, out_r=0, out_flags=0, flags=0, S1 data=0; in_ready=1 after reset.
REQ-030 Reset mid-operation SHALL discard all in-flight ops; no result emitted for them after reset release.

Structure
REQ-031 Op encodings (OP_DIV=0, OP_MUL=1) and default L/P SHALL live in shared package alu_pkg, used by ALU and this stage.
REQ-032 Exactly one sub-module: existing ALU, instantiated with (L, P); no other hierarchy.

Verification
REQ-033 Single op: DIV A=6 B=3, out_ready=1 -> out_r=2 two cycles after acceptance, out_valid one cycle.
REQ-034 Stream: MUL 2*3, 6*6, -16*1, -16*-1 on consecutive cycles, out_ready=1 -> out_r 6, 36, -16, 16 in order, no bubbles, in_ready constant 1.
REQ-035 Backpressure: DIV 6/4, -6/3, -6/-3 with out_ready=0 for 5 cycles -> in_ready low after 2 accepts, out_r=1 stable; release -> 1, -2, 2 in order, nothing lost/duplicated.
REQ-036 Flags chain: DIV 6/0 then DIV -16/-1 back-to-back -> flags after op1 equal ALU FlagsOut(6,0,flags=0); op2 FlagsIn equals that value.
REQ-037 flags_clr asserted on the s2_load edge of DIV 6/0 -> flags=0 next cycle, out_flags = ALU FlagsOut.
REQ-038 rst asserted with S1 and S2 full -> outputs zero immediately, out_valid stays 0 after release until new op accepted.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings, default widths and flag bit positions.
package alu_pkg;

    localparam int unsigned ALU_L = 16;
    localparam int unsigned ALU_P = 0;

    localparam int unsigned OP_DIV = 0;
    localparam int unsigned OP_MUL = 1;

    // Bits 0..3 describe the current op; FLAG_ERR is sticky through FlagsIn.
    localparam int unsigned FLAG_Z   = 0;
    localparam int unsigned FLAG_N   = 1;
    localparam int unsigned FLAG_V   = 2;
    localparam int unsigned FLAG_DZ  = 3;
    localparam int unsigned FLAG_ERR = 4;

endpackage

// File: rtl/alu_exec_stage_alu.sv
// Combinational signed divide/multiply ALU with flag generation and sticky error bit.
module alu_exec_stage_alu
    import alu_pkg::*;
#(
    parameter int unsigned L = ALU_L,
    parameter int unsigned P = ALU_P
) (
    input  logic        [P:0]   op,
    input  logic signed [L-1:0] a,
    input  logic signed [L-1:0] b,
    input  logic        [L-1:0] flags_in,
    output logic signed [L-1:0] r,
    output logic        [L-1:0] flags_out
);

    logic [2*L-1:0]      prod;
    logic signed [L-1:0] b_safe;
    logic signed [L-1:0] quot;
    logic signed [L-1:0] min_val;
    logic                ovf;
    logic                dz;
    logic                unused_flags;

    assign unused_flags = ^{flags_in[L-1:FLAG_ERR+1], flags_in[FLAG_ERR-1:0]};

    always_comb begin
        prod    = {{L{a[L-1]}}, a} * {{L{b[L-1]}}, b};
        min_val = {1'b1, {(L-1){1'b0}}};
        // Divisor forced non-zero so the divider never produces X.
        b_safe  = (b == '0) ? L'(1) : b;
        quot    = a / b_safe;
        r       = '0;
        ovf     = 1'b0;
        dz      = 1'b0;
        case (int'(op))
            OP_DIV: begin
                if (b == '0) begin
                    dz = 1'b1;
                end else if (a == min_val && b == '1) begin
                    ovf = 1'b1;
                    r   = a;
                end else begin
                    r = quot;
                end
            end
            OP_MUL: begin
                r   = prod[L-1:0];
                ovf = (prod[2*L-1:L] != {L{prod[L-1]}});
            end
            default: ;
        endcase
    end

    always_comb begin
        flags_out           = '0;
        flags_out[FLAG_Z]   = (r == '0);
        flags_out[FLAG_N]   = r[L-1];
        flags_out[FLAG_V]   = ovf;
        flags_out[FLAG_DZ]  = dz;
        flags_out[FLAG_ERR] = flags_in[FLAG_ERR] | ovf | dz;
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Two-register ALU execute stage (operand latch -> ALU -> result latch) with flag feedback.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int unsigned L = ALU_L,
    parameter int unsigned P = ALU_P
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [P:0]         in_op,
    input  logic signed [L-1:0] in_a,
    input  logic signed [L-1:0] in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [L-1:0] out_r,
    output logic [L-1:0]       out_flags,
    output logic [L-1:0]       flags,
    input  logic               flags_clr
);

    logic               s1_valid;
    logic [P:0]         s1_op;
    logic signed [L-1:0] s1_a;
    logic signed [L-1:0] s1_b;
    logic               s2_valid;
    logic               s2_load;
    logic               in_fire;
    logic signed [L-1:0] alu_r;
    logic [L-1:0]       alu_flags;

    assign s2_load   = s1_valid && (!s2_valid || out_ready);
    assign in_ready  = !s1_valid || s2_load;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = s2_valid;

    alu_exec_stage_alu #(
        .L(L),
        .P(P)
    ) u_alu (
        .op       (s1_op),
        .a        (s1_a),
        .b        (s1_b),
        .flags_in (flags),
        .r        (alu_r),
        .flags_out(alu_flags)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else begin
            if (in_fire) begin
                s1_valid <= 1'b1;
                s1_op    <= in_op;
                s1_a     <= in_a;
                s1_b     <= in_b;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            out_r     <= '0;
            out_flags <= '0;
        end else begin
            if (s2_load) begin
                s2_valid  <= 1'b1;
                out_r     <= alu_r;
                out_flags <= alu_flags;
            end else if (out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

    // Clear beats a coincident load; out_flags still records the ALU's view.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags <= '0;
        end else if (flags_clr) begin
            flags <= '0;
        end else if (s2_load) begin
            flags <= alu_flags;
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed-vector bench for alu_exec_stage with hand-computed results and flags.
module tb_alu_exec_stage;

    localparam int unsigned L = 16;
    localparam int unsigned P = 0;
    localparam logic [P:0] DIV_OP = 1'b0;
    localparam logic [P:0] MUL_OP = 1'b1;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [P:0]         in_op;
    logic signed [L-1:0] in_a;
    logic signed [L-1:0] in_b;
    logic               out_valid;
    logic               out_ready;
    logic signed [L-1:0] out_r;
    logic [L-1:0]       out_flags;
    logic [L-1:0]       flags;
    logic               flags_clr;

    int n_tests = 0;
    int n_fail  = 0;

    logic [L-1:0] sa[4]    = '{16'd2, 16'd6, 16'hfff0, 16'hfff0};
    logic [L-1:0] sb[4]    = '{16'd3, 16'd6, 16'd1, 16'hffff};
    logic [L-1:0] exp_r[4] = '{16'd6, 16'd36, 16'hfff0, 16'd16};
    logic [L-1:0] exp_f[4] = '{16'h0000, 16'h0000, 16'h0002, 16'h0000};

    alu_exec_stage #(
        .L(L),
        .P(P)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_r    (out_r),
        .out_flags(out_flags),
        .flags    (flags),
        .flags_clr(flags_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [L-1:0] got, input logic [L-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [P:0] op, input logic [L-1:0] a,
                         input logic [L-1:0] b);
        in_valid = v;
        in_op    = op;
        in_a     = a;
        in_b     = b;
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        flags_clr = 1'b0;
        drive(1'b0, DIV_OP, 16'd0, 16'd0);
        tick();
        tick();
        check("rst_out_valid", L'(out_valid), 16'd0);
        check("rst_out_r", out_r, 16'd0);
        check("rst_out_flags", out_flags, 16'd0);
        check("rst_flags", flags, 16'd0);
        check("rst_in_ready", L'(in_ready), 16'd1);
        rst = 1'b0;
        tick();

        // Single divide, latency check
        out_ready = 1'b1;
        drive(1'b1, DIV_OP, 16'd6, 16'd3);
        #1;
        check("single_in_ready", L'(in_ready), 16'd1);
        tick();
        drive(1'b0, DIV_OP, 16'd0, 16'd0);
        #1;
        check("single_not_yet", L'(out_valid), 16'd0);
        tick();
        check("single_valid", L'(out_valid), 16'd1);
        check("single_r", out_r, 16'd2);
        tick();
        check("single_retired", L'(out_valid), 16'd0);

        // Back-to-back multiplies, no bubbles
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive(1'b1, MUL_OP, sa[i], sb[i]);
            else drive(1'b0, MUL_OP, 16'd0, 16'd0);
            #1;
            if (i < 4) check("stream_in_ready", L'(in_ready), 16'd1);
            if (i >= 2) begin
                check("stream_valid", L'(out_valid), 16'd1);
                check("stream_r", out_r, exp_r[i-2]);
                check("stream_flags", out_flags, exp_f[i-2]);
            end
            tick();
        end
        check("stream_drained", L'(out_valid), 16'd0);

        // Backpressure with three divides
        out_ready = 1'b0;
        drive(1'b1, DIV_OP, 16'd6, 16'd4);
        tick();
        drive(1'b1, DIV_OP, 16'hfffa, 16'd3);
        #1;
        check("bp_second_ready", L'(in_ready), 16'd1);
        tick();
        drive(1'b1, DIV_OP, 16'hfffa, 16'hfffd);
        #1;
        for (int k = 0; k < 4; k++) begin
            check("bp_in_ready_low", L'(in_ready), 16'd0);
            check("bp_hold_valid", L'(out_valid), 16'd1);
            check("bp_hold_r", out_r, 16'd1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", L'(in_ready), 16'd1);
        tick();
        drive(1'b0, DIV_OP, 16'd0, 16'd0);
        #1;
        check("bp_r2_valid", L'(out_valid), 16'd1);
        check("bp_r2", out_r, 16'hfffe);
        tick();
        check("bp_r3_valid", L'(out_valid), 16'd1);
        check("bp_r3", out_r, 16'd2);
        tick();
        check("bp_drained", L'(out_valid), 16'd0);

        // Flag chain: divide by zero then -16/-1
        check("chain_flags_pre", flags, 16'd0);
        drive(1'b1, DIV_OP, 16'd6, 16'd0);
        tick();
        drive(1'b1, DIV_OP, 16'hfff0, 16'hffff);
        tick();
        drive(1'b0, DIV_OP, 16'd0, 16'd0);
        #1;
        check("chain_r1", out_r, 16'd0);
        check("chain_oflags1", out_flags, 16'h0019);
        check("chain_flags1", flags, 16'h0019);
        tick();
        check("chain_r2", out_r, 16'd16);
        check("chain_oflags2", out_flags, 16'h0010);
        check("chain_flags2", flags, 16'h0010);
        tick();

        // Clear coincident with load
        drive(1'b1, DIV_OP, 16'd6, 16'd0);
        tick();
        drive(1'b0, DIV_OP, 16'd0, 16'd0);
        flags_clr = 1'b1;
        #1;
        check("clr_flags_before", flags, 16'h0010);
        tick();
        flags_clr = 1'b0;
        #1;
        check("clr_flags", flags, 16'd0);
        check("clr_oflags", out_flags, 16'h0019);
        check("clr_valid", L'(out_valid), 16'd1);
        tick();

        // Reset with both stages full
        out_ready = 1'b0;
        drive(1'b1, MUL_OP, 16'hfffd, 16'd3);
        tick();
        drive(1'b1, MUL_OP, 16'd4, 16'd4);
        tick();
        drive(1'b0, DIV_OP, 16'd0, 16'd0);
        #1;
        check("full_valid", L'(out_valid), 16'd1);
        check("full_r", out_r, 16'hfff7);
        check("full_flags", flags, 16'h0002);
        check("full_in_ready", L'(in_ready), 16'd0);
        rst = 1'b1;
        #1;
        check("arst_valid", L'(out_valid), 16'd0);
        check("arst_r", out_r, 16'd0);
        check("arst_oflags", out_flags, 16'd0);
        check("arst_flags", flags, 16'd0);
        check("arst_in_ready", L'(in_ready), 16'd1);
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("post_rst_idle", L'(out_valid), 16'd0);
        end

        // Overflow cases: 300*300 and min/-1
        drive(1'b1, MUL_OP, 16'd300, 16'd300);
        tick();
        drive(1'b1, DIV_OP, 16'h8000, 16'hffff);
        tick();
        drive(1'b0, DIV_OP, 16'd0, 16'd0);
        #1;
        check("mul_ovf_r", out_r, 16'h5f90);
        check("mul_ovf_flags", out_flags, 16'h0014);
        tick();
        check("div_ovf_r", out_r, 16'h8000);
        check("div_ovf_flags", out_flags, 16'h0016);
        check("div_ovf_freg", flags, 16'h0016);
        tick();
        check("final_idle", L'(out_valid), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
